// File: rtl/mem_arbiter_pkg.sv
// Shared state/op encodings and defaults for the instruction/data memory arbiter.
package mem_arbiter_pkg;

  localparam int unsigned MEM_LAT_DEF = 4;
  localparam int unsigned CNT_W       = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    D_ACC = 2'd1,
    I_ACC = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OP_FETCH = 2'd0,
    OP_RD    = 2'd1,
    OP_WR    = 2'd2
  } op_t;

endpackage

// File: rtl/arb_lat_counter.sv
// Loadable down-counter with a zero flag; times fixed-latency operations.
module arb_lat_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         zero_c
);

  logic [W-1:0] count;

  // Saturates at zero so an idle enable cannot wrap around.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero_c = (count == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one fixed-latency memory between the core's fetch and data ports;
// data requests win, each access is sequenced and answered with a hit pulse.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned MEM_LAT = MEM_LAT_DEF,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] instr,
  output logic              i_hit,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_re,
  input  logic              d_we,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] rd_data,
  output logic              d_hit,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT - 1);

  state_t            state, state_nx;
  op_t               op, op_nx;
  logic [ADDR_W-1:0] addr_nx;
  logic [DATA_W-1:0] wdata_nx;
  logic [DATA_W-1:0] resp, resp_nx;
  logic              re_nx, we_nx;
  logic              cnt_load, cnt_en, cnt_zero;

  arb_lat_counter #(.W(CNT_W)) u_lat_cnt (
    .clk      (clk),
    .rst_n    (rst),
    .load     (cnt_load),
    .en       (cnt_en),
    .load_val (LAT_LOAD),
    .zero_c   (cnt_zero)
  );

  // State, latched access and strobes; reset drops the strobes immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      op        <= OP_FETCH;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      resp      <= '0;
    end else begin
      state     <= state_nx;
      op        <= op_nx;
      mem_addr  <= addr_nx;
      mem_wdata <= wdata_nx;
      mem_re    <= re_nx;
      mem_we    <= we_nx;
      resp      <= resp_nx;
    end
  end

  always_comb begin
    state_nx = state;
    op_nx    = op;
    addr_nx  = mem_addr;
    wdata_nx = mem_wdata;
    resp_nx  = resp;
    re_nx    = 1'b0;
    we_nx    = 1'b0;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    case (state)
      IDLE: begin
        cnt_load = 1'b1;
        if (d_re || d_we) begin
          // A simultaneous read and write request is served as a write.
          state_nx = D_ACC;
          addr_nx  = d_addr;
          wdata_nx = d_wdata;
          op_nx    = d_we ? OP_WR : OP_RD;
          re_nx    = !d_we;
          we_nx    = d_we;
        end else begin
          state_nx = I_ACC;
          addr_nx  = i_addr;
          op_nx    = OP_FETCH;
          re_nx    = 1'b1;
        end
      end
      D_ACC, I_ACC: begin
        if (cnt_zero) begin
          state_nx = RESP;
          if (op != OP_WR) begin
            resp_nx = mem_rdata;
          end
        end else begin
          cnt_en = 1'b1;
          re_nx  = mem_re;
          we_nx  = mem_we;
        end
      end
      RESP: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Hits are qualified by the core's live request so a redirected PC or a
  // withdrawn data request never sees a stale completion.
  assign i_hit   = (state == RESP) && (op == OP_FETCH) && (i_addr == mem_addr);
  assign instr   = i_hit ? resp : '0;
  assign d_hit   = (state == RESP) && (op != OP_FETCH) && (d_re || d_we);
  assign rd_data = ((state == RESP) && (op == OP_RD)) ? resp : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a MEM_LAT=4 and a MEM_LAT=1 instance share stimulus and
// are checked every cycle against a phase-count transaction model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] i_addr, d_addr, d_wdata;
  logic        d_re, d_we;

  logic [15:0] instr [2];
  logic [15:0] rd_data [2];
  logic [15:0] mem_addr [2];
  logic [15:0] mem_wdata [2];
  logic [15:0] mem_rdata [2];
  logic        i_hit [2];
  logic        d_hit [2];
  logic        mem_re [2];
  logic        mem_we [2];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.MEM_LAT(4), .ADDR_W(16), .DATA_W(16)) u_dut4 (
    .clk(clk), .rst(rst), .i_addr(i_addr), .instr(instr[0]), .i_hit(i_hit[0]),
    .d_addr(d_addr), .d_re(d_re), .d_we(d_we), .d_wdata(d_wdata),
    .rd_data(rd_data[0]), .d_hit(d_hit[0]), .mem_addr(mem_addr[0]),
    .mem_re(mem_re[0]), .mem_we(mem_we[0]), .mem_wdata(mem_wdata[0]),
    .mem_rdata(mem_rdata[0])
  );

  mem_arbiter #(.MEM_LAT(1), .ADDR_W(16), .DATA_W(16)) u_dut1 (
    .clk(clk), .rst(rst), .i_addr(i_addr), .instr(instr[1]), .i_hit(i_hit[1]),
    .d_addr(d_addr), .d_re(d_re), .d_we(d_we), .d_wdata(d_wdata),
    .rd_data(rd_data[1]), .d_hit(d_hit[1]), .mem_addr(mem_addr[1]),
    .mem_re(mem_re[1]), .mem_we(mem_we[1]), .mem_wdata(mem_wdata[1]),
    .mem_rdata(mem_rdata[1])
  );

  function automatic int lat(input int u);
    return (u == 0) ? 4 : 1;
  endfunction

  // Power-on memory contents.
  function automatic logic [15:0] pat(input logic [15:0] a);
    case (a)
      16'h0000: return 16'hB123;
      16'h2004: return 16'h5A5A;
      16'h0100: return 16'h7E01;
      default:  return a ^ 16'hC3C3;
    endcase
  endfunction

  // Memory environment: returns valid data only on the last strobe cycle.
  logic [15:0] envw [2][65536];
  bit          envv [2][65536];
  int          run [2];

  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (mem_we[u]) begin
        envw[u][mem_addr[u]] <= mem_wdata[u];
        envv[u][mem_addr[u]] <= 1'b1;
      end
      run[u] <= mem_re[u] ? run[u] + 1 : 0;
    end
  end

  function automatic logic [15:0] env_rd(input int u, input logic [15:0] a);
    return envv[u][a] ? envw[u][a] : pat(a);
  endfunction

  assign mem_rdata[0] = (mem_re[0] && run[0] == 3) ? env_rd(0, mem_addr[0]) : 16'hDEAD;
  assign mem_rdata[1] = (mem_re[1] && run[1] == 0) ? env_rd(1, mem_addr[1]) : 16'hDEAD;

  // Reference model: a transaction is a grant plus a phase count.
  logic [15:0] refw [2][65536];
  bit          refv [2][65536];
  bit          busy [2];
  int          phase [2];
  int          kind [2];   // 0 fetch, 1 read, 2 write
  logic [15:0] maddr [2];
  logic [15:0] mwd [2];
  logic [15:0] mresp [2];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int u = 0; u < 2; u++) busy[u] = 1'b0;
    end else begin
      for (int u = 0; u < 2; u++) begin
        if (!busy[u]) begin
          busy[u]  = 1'b1;
          phase[u] = 1;
          if (d_re || d_we) begin
            kind[u]  = d_we ? 2 : 1;
            maddr[u] = d_addr;
            mwd[u]   = d_wdata;
          end else begin
            kind[u]  = 0;
            maddr[u] = i_addr;
          end
        end else begin
          if (phase[u] == lat(u)) begin
            if (kind[u] == 2) begin
              refw[u][maddr[u]] = mwd[u];
              refv[u][maddr[u]] = 1'b1;
            end else begin
              mresp[u] = refv[u][maddr[u]] ? refw[u][maddr[u]] : pat(maddr[u]);
            end
          end
          phase[u]++;
          if (phase[u] == lat(u) + 2) busy[u] = 1'b0;
        end
      end
    end
  end

  task automatic cmp(input string nm, input int u, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s unit%0d actual=%0h required=%0h at %0t", nm, u, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin : chk
      logic acc, rsp, e_ih, e_dh;
      logic [15:0] e_instr, e_rd;
      acc     = busy[u] && phase[u] <= lat(u);
      rsp     = busy[u] && phase[u] == lat(u) + 1;
      e_ih    = rsp && kind[u] == 0 && i_addr == maddr[u];
      e_instr = e_ih ? mresp[u] : 16'h0;
      e_dh    = rsp && kind[u] != 0 && (d_re || d_we);
      e_rd    = (rsp && kind[u] == 1) ? mresp[u] : 16'h0;
      cmp("mem_re", u, 32'(mem_re[u]), 32'(acc && kind[u] != 2));
      cmp("mem_we", u, 32'(mem_we[u]), 32'(acc && kind[u] == 2));
      cmp("i_hit", u, 32'(i_hit[u]), 32'(e_ih));
      cmp("instr", u, 32'(instr[u]), 32'(e_instr));
      cmp("d_hit", u, 32'(d_hit[u]), 32'(e_dh));
      cmp("rd_data", u, 32'(rd_data[u]), 32'(e_rd));
      if (acc) cmp("mem_addr", u, 32'(mem_addr[u]), 32'(maddr[u]));
      if (acc && kind[u] == 2) cmp("mem_wdata", u, 32'(mem_wdata[u]), 32'(mwd[u]));
      if (!rst) begin
        cmp("rst_mem_addr", u, 32'(mem_addr[u]), 32'h0);
        cmp("rst_mem_wdata", u, 32'(mem_wdata[u]), 32'h0);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Ticks until unit 0 reports the chosen hit; n = cycles elapsed.
  task automatic wait_hit(input bit dside, input int budget, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!(dside ? d_hit[0] : i_hit[0]) && n < budget);
    if (!(dside ? d_hit[0] : i_hit[0])) begin
      checks++;
      failures++;
      $display("FAIL wait_hit timeout dside=%0d after %0d cycles", dside, n);
    end
  endtask

  initial begin
    int n, n2, wecnt, hits;
    rst = 1'b0; i_addr = 16'h0; d_addr = 16'h0; d_wdata = 16'h0;
    d_re = 1'b0; d_we = 1'b0;
    repeat (3) tick();
    cmp("reset_mem_re", 0, 32'(mem_re[0]), 32'h0);
    cmp("reset_i_hit", 0, 32'(i_hit[0]), 32'h0);

    // Fetch-only stream.
    rst = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      cmp("t2_fetch_re", 0, 32'(mem_re[0]), 32'h1);
    end
    tick();
    cmp("t2_i_hit", 0, 32'(i_hit[0]), 32'h1);
    cmp("t2_instr", 0, 32'(instr[0]), 32'hB123);
    tick();
    i_addr = 16'h0001;
    wait_hit(1'b0, 20, n);
    cmp("t2_gap", 0, 32'(n + 1), 32'd6);

    // Simultaneous data read and fetch: data first.
    tick();
    d_re = 1'b1; d_addr = 16'h2004; i_addr = 16'h0010;
    wait_hit(1'b1, 20, n);
    cmp("t3_d_lat", 0, 32'(n), 32'd5);
    cmp("t3_rd_data", 0, 32'(rd_data[0]), 32'h5A5A);
    tick();
    d_re = 1'b0;
    wait_hit(1'b0, 20, n2);
    cmp("t3_i_lat", 0, 32'(n + 1 + n2), 32'd11);
    cmp("t3_instr", 0, 32'(instr[0]), 32'hC3D3);

    // Write.
    tick();
    d_we = 1'b1; d_addr = 16'h3000; d_wdata = 16'hBEEF;
    n = 0; wecnt = 0;
    do begin
      tick();
      n++;
      if (mem_we[0]) wecnt++;
    end while (!d_hit[0] && n < 20);
    cmp("t4_we_cycles", 0, 32'(wecnt), 32'd4);
    cmp("t4_d_lat", 0, 32'(n), 32'd5);
    cmp("t4_rd_data", 0, 32'(rd_data[0]), 32'h0);
    tick();
    d_we = 1'b0;
    cmp("t4_mem", 0, 32'(env_rd(0, 16'h3000)), 32'hBEEF);

    // Jump during fetch.
    i_addr = 16'h0005;
    tick();
    tick();
    i_addr = 16'h0100;
    wait_hit(1'b0, 20, n);
    cmp("t5_lat", 0, 32'(n), 32'd9);
    cmp("t5_instr", 0, 32'(instr[0]), 32'h7E01);

    // Reset in the second cycle of a write.
    tick();
    d_we = 1'b1; d_addr = 16'h4000; d_wdata = 16'h1111;
    tick();
    cmp("t1_we_before", 0, 32'(mem_we[0]), 32'h1);
    tick();
    rst = 1'b0;
    #1;
    cmp("t1_we_drop", 0, 32'(mem_we[0]), 32'h0);
    cmp("t1_addr_drop", 0, 32'(mem_addr[0]), 32'h0);
    d_we = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    cmp("t1_idle_re", 0, 32'(mem_re[0]), 32'h0);
    hits = 0;
    repeat (8) begin
      tick();
      if (d_hit[0]) hits++;
    end
    cmp("t1_no_d_hit", 0, 32'(hits), 32'h0);

    // MEM_LAT=1 instance, aligned by a fresh reset.
    rst = 1'b0;
    tick();
    rst = 1'b1;
    d_re = 1'b1; d_addr = 16'h2004;
    tick();
    cmp("t6_re", 1, 32'(mem_re[1]), 32'h1);
    tick();
    cmp("t6_d_hit", 1, 32'(d_hit[1]), 32'h1);
    cmp("t6_rd_data", 1, 32'(rd_data[1]), 32'h5A5A);
    d_we = 1'b1; d_addr = 16'h3100; d_wdata = 16'h0F0F;
    tick();
    tick();
    cmp("t6_both_we", 1, 32'(mem_we[1]), 32'h1);
    cmp("t6_both_re", 1, 32'(mem_re[1]), 32'h0);
    tick();
    cmp("t6_wr_hit", 1, 32'(d_hit[1]), 32'h1);
    cmp("t6_wr_rd", 1, 32'(rd_data[1]), 32'h0);
    cmp("t6_lat4_hit", 0, 32'(d_hit[0]), 32'h1);
    cmp("t6_lat4_rd", 0, 32'(rd_data[0]), 32'h5A5A);
    d_re = 1'b0; d_we = 1'b0;
    tick();
    cmp("t6_mem", 1, 32'(env_rd(1, 16'h3100)), 32'h0F0F);
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-ported, fixed-latency unified memory between the processor's instruction-fetch port and its data port.
- Sits between the cache-less processor core and the memory array.
- Sequences each access, holds address and write data stable for the whole access, and returns one-cycle i_hit / d_hit completion pulses that drive the core's stall logic.
- Data accesses have priority over fetches.

Parameters:
MEM_LAT  4   memory access latency in cycles (legal range 1..15); mem_re/mem_we held this many cycles per access
ADDR_W   16  address width
DATA_W   16  data width

Ports:
clk        in   1       clock
rst        in   1       reset; asynchronous, active-low
i_addr     in   ADDR_W  fetch address (core PC); fetch always requested
instr      out  DATA_W  fetched instruction; valid while i_hit=1
i_hit      out  1       one-cycle fetch-complete pulse
d_addr     in   ADDR_W  data address
d_re       in   1       data read request (level, held until d_hit)
d_we       in   1       data write request (level, held until d_hit)
d_wdata    in   DATA_W  write data
rd_data    out  DATA_W  read data; valid while d_hit=1
d_hit      out  1       one-cycle data-complete pulse
mem_addr   out  ADDR_W  memory address
mem_re     out  1       memory read strobe
mem_we     out  1       memory write strobe
mem_wdata  out  DATA_W  memory write data
mem_rdata  in   DATA_W  memory read data; valid in the last strobe cycle

Behaviour:
- Reset (rst=0, async): state=IDLE, count=0; all outputs 0, including mem_we (drops immediately). Any in-flight access is abandoned with no hit pulse.
- FSM states: IDLE, D_ACC, I_ACC, RESP.
- IDLE:
  - If d_re or d_we is high, go to D_ACC. Latch d_addr, d_wdata, and op (write if d_we, else read).
  - Else go to I_ACC and latch i_addr.
  - Data wins every simultaneous contention.
  - d_re and d_we both high is treated as a write.
- D_ACC / I_ACC:
  - Last exactly MEM_LAT cycles, tracked by a down-counter loaded with MEM_LAT-1.
  - mem_addr and mem_wdata are driven from the latched values and are stable throughout.
  - mem_re=1 for reads and fetches; mem_we=1 for writes.
  - At the edge ending the final cycle (count=0): capture mem_rdata into the response register (reads and fetches only), then go to RESP.
- RESP (1 cycle): all strobes 0.
  - Fetch: i_hit=1 and instr=captured data, only if the current i_addr equals the latched fetch address. Otherwise no pulse (the PC changed due to jump or flush) and the result is discarded.
  - Data: d_hit=1 only if a data request is still asserted (d_re|d_we). A write always completes in memory even when d_hit is suppressed. rd_data=captured data for reads and 0 for writes.
  - Next state is IDLE.
- Latency: a request visible in IDLE at cycle 0 produces its hit in cycle MEM_LAT+1. Peak throughput is one access per MEM_LAT+2 cycles.
- Outside RESP: instr, rd_data, i_hit and d_hit are 0. Response data registers hold their values but outputs are gated.
- Inputs changing during an access have no effect; only latched values are used.
- MEM_LAT=1: the access state lasts a single cycle; the counter is unused.

Decomposition:
- Shared package:
  - state enum (IDLE, D_ACC, I_ACC, RESP, 2-bit encoding)
  - op encoding (OP_FETCH, OP_RD, OP_WR)
  - default MEM_LAT constant
- One sub-module, arb_lat_counter:
  - loadable 4-bit down-counter with load, enable and a zero flag
  - reused later by the SPART transmit scheduler

Test Plan:
1. Reset mid-write: assert rst low during the 2nd cycle of a D_ACC write. mem_we and all outputs go 0 immediately; after release the FSM is in IDLE and no d_hit occurs.
2. Fetch-only stream, MEM_LAT=4: i_addr=0x0000 held. mem_re=1 with mem_addr=0x0000 for cycles 1-4, capture mem_rdata=0xB123, then i_hit=1 with instr=0xB123 in cycle 5. Advance i_addr to 0x0001; the next i_hit arrives 6 cycles later.
3. Simultaneous requests: d_re=1, d_addr=0x2004, with i_addr=0x0010 pending. The data access is granted first and d_hit arrives in cycle 5 with rd_data=mem[0x2004]. The fetch of 0x0010 starts in the following IDLE cycle and i_hit arrives in cycle 11.
4. Write: d_we=1, d_addr=0x3000, d_wdata=0xBEEF. mem_we=1 for exactly 4 cycles with stable addr/data, then d_hit=1 and rd_data=0. mem[0x3000]=0xBEEF.
5. Jump during fetch: i_addr changes from 0x0005 to 0x0100 in cycle 2 of I_ACC. No i_hit for 0x0005; the next fetch of 0x0100 completes with i_hit carrying mem[0x0100].
6. MEM_LAT=1 build: each read completes with d_hit in cycle 2. Both d_re and d_we high produce a write (mem_we=1, mem_re=0).
